// File: rtl/mux_pkg.sv
// Shared parameters for the VC mux, the destination FIFO and their benches.
package mux_pkg;

  localparam int BITNUMBER       = 5;
  localparam int ADDR_WIDTH      = 2;
  localparam int ALMOST_FULL_TH  = 3;
  localparam int ALMOST_EMPTY_TH = 1;

  function automatic int depth(input int aw);
    return 2 ** aw;
  endfunction

  localparam int DEPTH = depth(ADDR_WIDTH);

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x W register file: synchronous write, registered read.
// Memory contents survive reset; only the read register clears.
module fifo_mem
  import mux_pkg::*;
#(
  parameter int W  = BITNUMBER,
  parameter int AW = ADDR_WIDTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [2**AW];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dest_fifo.sv
// Destination FIFO behind the 2:1 VC mux; pointers, count, flags.
// Define DEST_FIFO_ERR_EN for a sticky overflow/underflow flag.
module dest_fifo
  import mux_pkg::*;
#(
  parameter int BITNUMBER       = mux_pkg::BITNUMBER,
  parameter int ADDR_WIDTH      = mux_pkg::ADDR_WIDTH,
  parameter int ALMOST_FULL_TH  = mux_pkg::ALMOST_FULL_TH,
  parameter int ALMOST_EMPTY_TH = mux_pkg::ALMOST_EMPTY_TH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid_in,
  input  logic [BITNUMBER-1:0] data_in,
  input  logic                 pop,
  output logic [BITNUMBER-1:0] data_out,
  output logic                 valid_out,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 fifo_error
);

  localparam logic [ADDR_WIDTH:0] CNT_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] AF_TH    = ALMOST_FULL_TH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_TH    = ALMOST_EMPTY_TH[ADDR_WIDTH:0];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  valid_q;
  logic                  pop_ok, push_ok;

  assign empty        = (count_q == '0);
  assign full         = (count_q == CNT_FULL);
  assign almost_full  = (count_q >= AF_TH);
  assign almost_empty = (count_q <= AE_TH);

  // A full FIFO can still accept a word when a pop frees its slot
  assign pop_ok  = pop & ~empty;
  assign push_ok = valid_in & (~full | pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop_ok) count_d = count_q + 1'b1;
    if (pop_ok && !push_ok) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= pop_ok;
    end
  end

  assign valid_out = valid_q;

  fifo_mem #(
    .W (BITNUMBER),
    .AW(ADDR_WIDTH)
  ) u_mem (
    .clk    (clk),
    .reset  (reset),
    .we_i   (push_ok & ~reset),
    .waddr_i(wr_ptr_q),
    .wdata_i(data_in),
    .re_i   (pop_ok),
    .raddr_i(rd_ptr_q),
    .rdata_o(data_out)
  );

`ifdef DEST_FIFO_ERR_EN
  logic err_q;
  logic ovf, udf;

  assign ovf = valid_in & full & ~pop_ok;
  assign udf = pop & empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (ovf || udf) begin
      err_q <= 1'b1;
    end
  end

  assign fifo_error = err_q;
`else
  assign fifo_error = 1'b0;
`endif

endmodule
